// File: rtl/byte_packer64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer64_pkg
//  Description : Shared widths and FSM state encoding for the byte packer
//                feeding the 64-bit register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_packer64_pkg;

  localparam int WORD_W         = 64;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 8;
  // out_count must represent 1..8, so it needs one more bit than a lane index.
  localparam int CNT_W          = 4;
  localparam int IDX_W          = 3;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : byte_packer64_pkg
`default_nettype wire

// File: rtl/byte_lane_insert.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_insert
//  Description : Combinational lane replace. Returns word_in with the byte
//                lane selected by idx overwritten by byte_in.
//                LSB_FIRST=1 : idx 0 -> bits [7:0]
//                LSB_FIRST=0 : idx 0 -> bits [63:56]
//  Ports       : word_in  [63:0] word to modify
//                byte_in  [7:0]  byte to insert
//                idx      [2:0]  byte index in arrival order
//                word_out [63:0] modified word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_insert
  import byte_packer64_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] word_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word_out
);

  logic [IDX_W-1:0] lane;

  always_comb begin
    // For MSB-first order, arrival index k maps to lane 7-k, which for a
    // 3-bit index is simply its bitwise inverse.
    lane     = LSB_FIRST ? idx : ~idx;
    word_out = word_in;
    // Lane base bit = lane * 8.
    word_out[{lane, 3'b000} +: BYTE_W] = byte_in;
  end

endmodule : byte_lane_insert
`default_nettype wire

// File: rtl/byte_packer64.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer64
//  Description : Collects bytes over a valid/ready handshake, packs eight of
//                them into a 64-bit word and presents it on a valid/ready
//                output. load_en pulses for the one cycle in which the word
//                is taken and drives the downstream register's En input.
//                flush closes a partially filled word (zero-padded lanes).
//  Ports       : Clk        rising-edge clock
//                Rst        synchronous active-high reset
//                in_byte    [7:0]  input byte
//                in_valid   input byte valid
//                in_ready   packer accepts a byte this cycle
//                flush      close the current partial word
//                out_word   [63:0] packed word
//                out_valid  out_word valid and stable
//                out_ready  consumer takes out_word this cycle
//                out_count  [3:0]  valid bytes in out_word (1..8)
//                load_en    out_valid & out_ready pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer64
  import byte_packer64_pkg::WORD_W;
  import byte_packer64_pkg::BYTE_W;
  import byte_packer64_pkg::CNT_W;
  import byte_packer64_pkg::IDX_W;
  import byte_packer64_pkg::state_e;
  import byte_packer64_pkg::FILL;
  import byte_packer64_pkg::HOLD;
#(
  parameter bit LSB_FIRST      = 1'b1,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              load_en
);

  // Only the 8-byte configuration is implemented.
  if (BYTES_PER_WORD != byte_packer64_pkg::BYTES_PER_WORD) begin : g_bpw_check
    $error("byte_packer64: BYTES_PER_WORD must be 8");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q,   cnt_d;
  logic [WORD_W-1:0]   buf_q,   buf_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                accept;
  logic [WORD_W-1:0]   ins_word;
  logic [CNT_W-1:0]    held_plus_one;

  byte_lane_insert #(
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_insert (
    .word_in  (buf_q),
    .byte_in  (in_byte),
    .idx      (cnt_q),
    .word_out (ins_word)
  );

  assign in_ready      = (state_q == FILL) & ~Rst;
  assign accept        = in_valid & in_ready;
  assign held_plus_one = {1'b0, cnt_q} + CNT_W'(1);

  assign out_valid     = (state_q == HOLD);
  // Gated by Rst so that a reset landing on a handshake cycle discards the
  // word instead of loading it downstream.
  assign load_en       = out_valid & out_ready & ~Rst;
  assign out_word      = buf_q;
  assign out_count     = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    count_d = count_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          buf_d = ins_word;
          // A same-cycle byte is packed before flush closes the word.
          if ((cnt_q == IDX_W'(BYTES_PER_WORD - 1)) || flush) begin
            state_d = HOLD;
            count_d = held_plus_one;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else if (flush && (cnt_q != '0)) begin
          // Flush on an empty buffer is dropped so no empty word appears.
          state_d = HOLD;
          count_d = {1'b0, cnt_q};
          cnt_d   = '0;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          buf_d   = '0;
          count_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule : byte_packer64
`default_nettype wire

// File: tb/tb_byte_packer64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_packer64
//  Description : Self-checking bench for byte_packer64. Two instances (LSB-
//                and MSB-first) share stimulus. A behavioural model records
//                the byte list of each closed word into a scoreboard; a
//                monitor pops and compares whenever load_en fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_packer64;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        lsb_in_ready,  msb_in_ready;
  logic [63:0] lsb_out_word,  msb_out_word;
  logic        lsb_out_valid, msb_out_valid;
  logic [3:0]  lsb_out_count, msb_out_count;
  logic        lsb_load_en,   msb_load_en;

  int checks = 0;
  int errors = 0;

  // Model state: bytes of the word being filled, in arrival order
  // (byte k kept at [8k+7:8k] of cur_bytes), plus the scoreboard.
  logic [63:0] cur_bytes;
  int          cur_n;
  bit          holding;
  logic [63:0] sb_bytes[$];
  int          sb_n[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_packer64 #(.LSB_FIRST(1'b1), .BYTES_PER_WORD(8)) u_lsb (
    .Clk(clk), .Rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(lsb_in_ready), .flush(flush), .out_word(lsb_out_word),
    .out_valid(lsb_out_valid), .out_ready(out_ready),
    .out_count(lsb_out_count), .load_en(lsb_load_en)
  );

  byte_packer64 #(.LSB_FIRST(1'b0), .BYTES_PER_WORD(8)) u_msb (
    .Clk(clk), .Rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(msb_in_ready), .flush(flush), .out_word(msb_out_word),
    .out_valid(msb_out_valid), .out_ready(out_ready),
    .out_count(msb_out_count), .load_en(msb_load_en)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the expected word from an arrival-ordered byte list.
  function automatic logic [63:0] expect_word(input logic [63:0] bytes, input int n, input bit lsb);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (lsb) w[8*k +: 8]      = bytes[8*k +: 8];
      else     w[56 - 8*k +: 8] = bytes[8*k +: 8];
    end
    return w;
  endfunction

  // One cycle: drive at the falling edge, check settled outputs, advance model.
  task automatic step(input bit v, input logic [7:0] b, input bit f, input bit r, input bit rs);
    in_valid  = v;
    in_byte   = b;
    flush     = f;
    out_ready = r;
    rst       = rs;
    #1;
    chk("in_ready_lsb",  {63'd0, lsb_in_ready},  {63'd0, !holding && !rs});
    chk("in_ready_msb",  {63'd0, msb_in_ready},  {63'd0, !holding && !rs});
    chk("out_valid_lsb", {63'd0, lsb_out_valid}, {63'd0, holding});
    chk("out_valid_msb", {63'd0, msb_out_valid}, {63'd0, holding});
    chk("load_en_lsb",   {63'd0, lsb_load_en},   {63'd0, holding && r && !rs});
    chk("load_en_msb",   {63'd0, msb_load_en},   {63'd0, holding && r && !rs});
    if (holding && sb_bytes.size() > 0) begin
      chk("hold_word_lsb", lsb_out_word,
          expect_word(sb_bytes[sb_bytes.size()-1], sb_n[sb_n.size()-1], 1'b1));
      chk("hold_word_msb", msb_out_word,
          expect_word(sb_bytes[sb_bytes.size()-1], sb_n[sb_n.size()-1], 1'b0));
    end
    if (rs) begin
      if (holding) begin
        void'(sb_bytes.pop_back());
        void'(sb_n.pop_back());
      end
      holding   = 1'b0;
      cur_n     = 0;
      cur_bytes = '0;
    end else if (holding) begin
      if (r) holding = 1'b0;
    end else begin
      if (v) begin
        cur_bytes[8*cur_n +: 8] = b;
        cur_n++;
      end
      if (cur_n == 8 || (f && cur_n > 0)) begin
        sb_bytes.push_back(cur_bytes);
        sb_n.push_back(cur_n);
        holding   = 1'b1;
        cur_n     = 0;
        cur_bytes = '0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: decoupled from stimulus, pops one entry per load_en.
  initial begin
    logic [63:0] eb;
    int          en;
    forever begin
      @(negedge clk);
      #2;
      if (lsb_load_en || msb_load_en) begin
        if (sb_bytes.size() == 0) begin
          chk("unexpected_load_en", {63'd0, lsb_load_en}, 64'd0);
        end else begin
          eb = sb_bytes.pop_front();
          en = sb_n.pop_front();
          chk("word_lsb",  lsb_out_word, expect_word(eb, en, 1'b1));
          chk("word_msb",  msb_out_word, expect_word(eb, en, 1'b0));
          chk("count_lsb", {60'd0, lsb_out_count}, 64'(en));
          chk("count_msb", {60'd0, msb_out_count}, 64'(en));
        end
      end
    end
  end

  initial begin
    cur_bytes = '0;
    cur_n     = 0;
    holding   = 1'b0;

    // Reset for two cycles with in_valid high.
    rst = 1'b1; in_valid = 1'b1; in_byte = 8'hAA; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, lsb_in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, lsb_out_valid}, 64'd0);
    chk("rst_out_word",  lsb_out_word,           64'd0);
    chk("rst_out_count", {60'd0, lsb_out_count}, 64'd0);
    chk("rst_word_msb",  msb_out_word,           64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Full word, ready held high.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0);
    chk("full_lsb_literal", lsb_out_word, 64'h0807060504030201);
    chk("full_cnt_literal", {60'd0, lsb_out_count}, 64'd8);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // MSB-first pattern.
    begin
      logic [63:0] pat;
      pat = 64'h5911223344556677;
      for (int i = 0; i < 8; i++) step(1'b1, pat[56 - 8*i +: 8], 1'b0, 1'b0, 1'b0);
    end
    chk("msb_literal", msb_out_word, 64'h5911223344556677);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Flush with same-cycle byte, then flush on empty buffer.
    step(1'b1, 8'h59, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("flush_literal", lsb_out_word, 64'h00000000003CA559);
    chk("flush_count",   {60'd0, lsb_out_count}, 64'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Backpressure: word held with new bytes offered.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-word, then a fresh word.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("post_rst_literal", lsb_out_word, 64'h1716151413121110);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during HOLD with out_ready high: word discarded, no load.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
    end

    // Drain.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("scoreboard_empty", 64'(sb_bytes.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_byte_packer64
`default_nettype wire
